// File: rtl/bird_move_ctrl.sv
// Bird motion control: turns the raw button and crash flag into clean one-cycle
// flap (in) and gravity (fall) pulses for the bird cells, gated by a WAIT/RUN/DEAD phase FSM.
module bird_move_ctrl #(
  parameter int FALL_PERIOD = 25_000_000,
  parameter int CNT_W       = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic crash,
  output logic in,
  output logic fall,
  output logic running
);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_RUN,
    ST_DEAD
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FALL_PERIOD - 1);

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             r_v1;
  logic             r_v2;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in;
  logic             r_fall;
  logic             r_running;
  logic             w_press;

  assign w_press = r_armed & r_s2 & ~r_s3;

  // r_v1/r_v2 mark that r_s2 holds a real post-reset button sample, so a button
  // held through reset cannot arm the edge detector off the cleared synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_v1 <= 1'b1;
      r_v2 <= r_v1;
      if (r_v2 && !r_s2) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_WAIT;
      r_cnt     <= '0;
      r_in      <= 1'b0;
      r_fall    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_in   <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_WAIT: begin
          r_cnt <= '0;
          if (w_press) begin
            r_in      <= 1'b1;
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          // Crash beats a flap, and a flap beats a coincident gravity tick.
          if (crash) begin
            r_cnt     <= '0;
            r_state   <= ST_DEAD;
            r_running <= 1'b0;
          end else if (w_press) begin
            r_in  <= 1'b1;
            r_cnt <= '0;
          end else if (r_cnt == LAST_CNT) begin
            r_fall <= 1'b1;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt     <= '0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign in      = r_in;
  assign fall    = r_fall;
  assign running = r_running;

endmodule

// File: tb/tb_bird_move_ctrl.sv
// Directed self-checking bench for bird_move_ctrl with a short gravity period
// so flap, gravity, crash and reset interactions fit in a few dozen cycles.
module tb_bird_move_ctrl;

  logic clk;
  logic reset;
  logic btn;
  logic crash;
  logic inPulse;
  logic fallPulse;
  logic isRunning;

  int checks = 0;
  int errors = 0;

  bird_move_ctrl #(
    .FALL_PERIOD(4),
    .CNT_W      (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn),
    .crash  (crash),
    .in     (inPulse),
    .fall   (fallPulse),
    .running(isRunning)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after an edge and outputs are sampled there too.
  task automatic applyStimulus(input logic b, input logic c);
    btn   = b;
    crash = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " in"}, inPulse, 0);
    checkOutput({tag, " fall"}, fallPulse, 0);
    checkOutput({tag, " running"}, isRunning, 0);
  endtask

  initial begin
    reset = 1'b1;
    btn   = 1'b0;
    crash = 1'b0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkIdle("reset");
    reset = 1'b0;
    for (int e = 0; e < 3; e++) applyStimulus(1'b0, 1'b0);
    checkIdle("warmup");

    // Long hold gives one flap; then a re-press lands on a due gravity tick (edge 19).
    for (int e = 1; e <= 24; e++) begin
      applyStimulus((e <= 10) || (e == 17) || (e == 18), 1'b0);
      checkOutput($sformatf("t1 in e%0d", e), inPulse, (e == 3) || (e == 19));
      checkOutput($sformatf("t1 fall e%0d", e), fallPulse,
                  (e == 7) || (e == 11) || (e == 15) || (e == 23));
      checkOutput($sformatf("t1 running e%0d", e), isRunning, e >= 3);
    end

    // Button held through reset must be released and pressed again.
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkIdle("t3 reset");
    reset = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      applyStimulus((e <= 5) || ((e >= 11) && (e <= 13)), 1'b0);
      checkOutput($sformatf("t3 in e%0d", e), inPulse, e == 13);
      checkOutput($sformatf("t3 fall e%0d", e), fallPulse, e == 17);
      checkOutput($sformatf("t3 running e%0d", e), isRunning, e >= 13);
    end

    // Crash coincides with both a press and a terminal count at edge 3.
    for (int e = 1; e <= 24; e++) begin
      applyStimulus((e <= 2) || ((e >= 8) && (e <= 10)) || ((e >= 15) && (e <= 17)), e == 3);
      checkOutput($sformatf("t4 in e%0d", e), inPulse, 0);
      checkOutput($sformatf("t4 fall e%0d", e), fallPulse, 0);
      checkOutput($sformatf("t4 running e%0d", e), isRunning, e <= 2);
    end

    // Crash while waiting is ignored.
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    reset = 1'b0;
    for (int e = 0; e < 3; e++) applyStimulus(1'b0, 1'b0);
    for (int e = 1; e <= 19; e++) begin
      applyStimulus((e == 11) || (e == 12), e <= 10);
      checkOutput($sformatf("t5 in e%0d", e), inPulse, e == 13);
      checkOutput($sformatf("t5 fall e%0d", e), fallPulse, e == 17);
      checkOutput($sformatf("t5 running e%0d", e), isRunning, e >= 13);
    end

    // Reset mid-run with the counter at 2, one edge before it would reach 3.
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkIdle("t6 reset");
    reset = 1'b0;
    for (int e = 1; e <= 28; e++) begin
      applyStimulus((e == 21) || (e == 22), 1'b0);
      checkOutput($sformatf("t6 in e%0d", e), inPulse, e == 23);
      checkOutput($sformatf("t6 fall e%0d", e), fallPulse, e == 27);
      checkOutput($sformatf("t6 running e%0d", e), isRunning, e >= 23);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bird_move_ctrl.md
Name: bird_move_ctrl

Overview:
Upstream control stage for the bird column cells. It turns the raw player button and a crash flag into clean one-cycle motion pulses, in (flap up) and fall (gravity tick), which are broadcast to every bird light cell. It contains a 2-FF synchroniser, an armed rising-edge detector, a gravity period counter and a WAIT/RUN/DEAD game-phase FSM.

Parameters:
FALL_PERIOD, 25_000_000, clocks between gravity ticks while running; legal range 2..2^CNT_W.
CNT_W, 25, width of the gravity counter.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
btn  input  1  raw player button, active high, asynchronous to clk.
crash  input  1  synchronous crash flag from collision logic, level.
in  output  1  registered one-cycle flap pulse to the bird cells.
fall  output  1  registered one-cycle gravity pulse to the bird cells.
running  output  1  high while the FSM is in RUN.

Behaviour:
- Reset, sampled on a posedge: FSM=WAIT, counter=0, sync regs=0, armed=0; in=0, fall=0, running=0 from the next cycle. Reset mid-game aborts immediately; no pulse is emitted on the reset edge.
- Synchroniser: s1<=btn, s2<=s1, s3<=s2.
- armed: set when s2==0 and cleared only by reset. A button held through reset produces no flap until it has been released and pressed again.
- press = armed & s2 & ~s3. One press per rising edge, regardless of hold length.
- Latency: btn first sampled high at edge E0 -> in high for exactly the cycle after edge E0+2, i.e. 3 edges.
- FSM WAIT: fall never asserts; the counter is held at 0. A press -> in<=1, counter<=0, go to RUN.
- FSM RUN: each edge,
  - press -> in<=1, counter<=0, fall<=0. A flap always wins over a coincident gravity tick.
  - else if counter==FALL_PERIOD-1 -> fall<=1, counter<=0.
  - else counter<=counter+1, and in and fall are 0.
- Gravity timing: the first fall follows an in pulse by exactly FALL_PERIOD cycles. After that, fall repeats every FALL_PERIOD cycles until the next flap.
- crash in RUN: go to DEAD on that edge. in and fall are forced 0 on that edge, even if press or terminal count coincide.
- crash in WAIT: ignored.
- FSM DEAD: in=0, fall=0, counter held at 0, presses ignored. The only exit is reset.
- running = (state==RUN), registered, so it goes high on the same edge as the first in.
- Invariant: in & fall is never 1.
- Counter arithmetic is unsigned CNT_W bits and never wraps past FALL_PERIOD-1.

Test Plan (FALL_PERIOD=4 unless noted):
1. Reset, then hold btn=1 for 10 cycles -> exactly one in pulse, 3 edges after first sample; running rises with it; fall pulses at +4, +8 cycles after in.
2. In RUN, re-press btn so the in pulse lands on the cycle a fall was due (counter==3) -> in=1, fall=0, the next fall arrives 4 cycles later.
3. btn held high through a reset pulse, released 5 cycles later, pressed again -> no in until the second press; in appears 3 edges after it.
4. In RUN, assert crash for 1 cycle coincident with a press -> no in pulse; running=0 next cycle; further presses and ticks produce no pulses for 20 cycles.
5. In WAIT, crash=1 for 10 cycles, then press -> FSM still enters RUN, in pulses, fall follows 4 cycles later.
6. Reset asserted mid-RUN with counter==2 -> in=fall=running=0 after the edge; no fall for 20 cycles until a new press.
